// File: rtl/robot_move_controller.sv
// Single-step robot move sequencer: checks the target map cell, moves, blocks,
// or clears debris (writing the cell back to 0) before answering the requester.
module robot_move_controller #(
  parameter int unsigned ROWS      = 11,
  parameter int unsigned COLS      = 20,
  parameter int unsigned START_ROW = 0,
  parameter int unsigned START_COL = 0,
  parameter int unsigned LIGHT_CYC = 3,
  parameter int unsigned MED_CYC   = 6,
  parameter int unsigned HEAVY_CYC = 9
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_dir,
  output logic       cmd_ready,
  output logic       resp_valid,
  output logic [1:0] resp_code,
  output logic       at_black,
  output logic [3:0] pos_row,
  output logic [4:0] pos_col,
  output logic       busy,
  output logic       clearing,
  output logic       map_rd_en,
  output logic [3:0] map_row,
  output logic [4:0] map_col,
  input  logic [3:0] map_rd_data,
  output logic       map_wr_en,
  output logic [3:0] map_wr_data
);

  localparam int unsigned RW    = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [1:0] RC_MOVED         = 2'd0;
  localparam logic [1:0] RC_WALL          = 2'd1;
  localparam logic [1:0] RC_EDGE          = 2'd2;
  localparam logic [1:0] RC_CLEARED_MOVED = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_EVAL, ST_CLEAR, ST_WRITE, ST_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    pos_row_q, pos_row_d;
  logic [CW-1:0]    pos_col_q, pos_col_d;
  logic [RW-1:0]    tgt_row_q, tgt_row_d;
  logic [CW-1:0]    tgt_col_q, tgt_col_d;
  logic             edge_q, edge_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_code_q, resp_code_d;
  logic             at_black_q, at_black_d;
  logic             busy_q, busy_d;
  logic             clearing_q, clearing_d;
  logic             map_rd_en_q, map_rd_en_d;
  logic             map_wr_en_q, map_wr_en_d;
  logic [RW-1:0]    map_row_q, map_row_d;
  logic [CW-1:0]    map_col_q, map_col_d;

  logic [RW-1:0]    tgt_row_c;
  logic [CW-1:0]    tgt_col_c;
  logic             edge_c;

  // Target cell and out-of-bounds flag for the command currently offered.
  always_comb begin
    tgt_row_c = pos_row_q;
    tgt_col_c = pos_col_q;
    edge_c    = 1'b0;
    case (cmd_dir)
      DIR_N: begin
        edge_c    = (pos_row_q == '0);
        tgt_row_c = pos_row_q - RW'(1);
      end
      DIR_E: begin
        edge_c    = (pos_col_q == CW'(COLS - 1));
        tgt_col_c = pos_col_q + CW'(1);
      end
      DIR_S: begin
        edge_c    = (pos_row_q == RW'(ROWS - 1));
        tgt_row_c = pos_row_q + RW'(1);
      end
      DIR_W: begin
        edge_c    = (pos_col_q == '0);
        tgt_col_c = pos_col_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pos_row_q    <= RW'(START_ROW);
      pos_col_q    <= CW'(START_COL);
      tgt_row_q    <= '0;
      tgt_col_q    <= '0;
      edge_q       <= 1'b0;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_code_q  <= RC_MOVED;
      at_black_q   <= 1'b0;
      busy_q       <= 1'b0;
      clearing_q   <= 1'b0;
      map_rd_en_q  <= 1'b0;
      map_wr_en_q  <= 1'b0;
      map_row_q    <= '0;
      map_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      pos_row_q    <= pos_row_d;
      pos_col_q    <= pos_col_d;
      tgt_row_q    <= tgt_row_d;
      tgt_col_q    <= tgt_col_d;
      edge_q       <= edge_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      at_black_q   <= at_black_d;
      busy_q       <= busy_d;
      clearing_q   <= clearing_d;
      map_rd_en_q  <= map_rd_en_d;
      map_wr_en_q  <= map_wr_en_d;
      map_row_q    <= map_row_d;
      map_col_q    <= map_col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = ST_CHECK;
      ST_CHECK: state_d = edge_q ? ST_RESP : ST_EVAL;
      ST_EVAL: begin
        if (map_rd_data == 4'd3 || map_rd_data == 4'd4 || map_rd_data == 4'd5) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_CLEAR: if (cnt_q <= CNT_W'(1)) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath updates; status strobes are registered from the next state.
  always_comb begin
    pos_row_d   = pos_row_q;
    pos_col_d   = pos_col_q;
    tgt_row_d   = tgt_row_q;
    tgt_col_d   = tgt_col_q;
    edge_d      = edge_q;
    cnt_d       = cnt_q;
    resp_code_d = resp_code_q;
    at_black_d  = at_black_q;
    map_row_d   = map_row_q;
    map_col_d   = map_col_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          edge_d    = edge_c;
          tgt_row_d = tgt_row_c;
          tgt_col_d = tgt_col_c;
          if (!edge_c) begin
            map_row_d = tgt_row_c;
            map_col_d = tgt_col_c;
          end
        end
      end
      ST_CHECK: if (edge_q) resp_code_d = RC_EDGE;
      ST_EVAL: begin
        case (map_rd_data)
          4'd0, 4'd2: begin
            pos_row_d   = tgt_row_q;
            pos_col_d   = tgt_col_q;
            resp_code_d = RC_MOVED;
            at_black_d  = (map_rd_data == 4'd2);
          end
          4'd3:    cnt_d = CNT_W'(LIGHT_CYC);
          4'd4:    cnt_d = CNT_W'(MED_CYC);
          4'd5:    cnt_d = CNT_W'(HEAVY_CYC);
          default: resp_code_d = RC_WALL;
        endcase
      end
      ST_CLEAR: cnt_d = cnt_q - CNT_W'(1);
      ST_WRITE: begin
        pos_row_d   = tgt_row_q;
        pos_col_d   = tgt_col_q;
        resp_code_d = RC_CLEARED_MOVED;
        at_black_d  = 1'b0;
      end
      default: ;
    endcase
    cmd_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    clearing_d   = (state_d == ST_CLEAR);
    map_rd_en_d  = (state_d == ST_CHECK) && !edge_d;
    map_wr_en_d  = (state_d == ST_WRITE);
  end

  assign cmd_ready   = cmd_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_code   = resp_code_q;
  assign at_black    = at_black_q;
  assign pos_row     = pos_row_q;
  assign pos_col     = pos_col_q;
  assign busy        = busy_q;
  assign clearing    = clearing_q;
  assign map_rd_en   = map_rd_en_q;
  assign map_wr_en   = map_wr_en_q;
  assign map_row     = map_row_q;
  assign map_col     = map_col_q;
  assign map_wr_data = '0;

endmodule

// File: tb/tb_robot_move_controller.sv
// Directed bench for robot_move_controller: behavioural map memory plus a
// queue of expected responses popped when the controller answers.
module tb_robot_move_controller;

  localparam int unsigned ROWS = 11;
  localparam int unsigned COLS = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_dir = 2'd0;
  logic       cmd_ready, resp_valid, at_black, busy, clearing;
  logic [1:0] resp_code;
  logic [3:0] pos_row, map_row, map_rd_data, map_wr_data;
  logic [4:0] pos_col, map_col;
  logic       map_rd_en, map_wr_en;

  robot_move_controller dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_dir     (cmd_dir),
    .cmd_ready   (cmd_ready),
    .resp_valid  (resp_valid),
    .resp_code   (resp_code),
    .at_black    (at_black),
    .pos_row     (pos_row),
    .pos_col     (pos_col),
    .busy        (busy),
    .clearing    (clearing),
    .map_rd_en   (map_rd_en),
    .map_row     (map_row),
    .map_col     (map_col),
    .map_rd_data (map_rd_data),
    .map_wr_en   (map_wr_en),
    .map_wr_data (map_wr_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] code;
    int         row;
    int         col;
    logic       black;
    int         lat;
    int         clr;
    int         rd;
    int         wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  logic [3:0] mem [ROWS][COLS];
  logic       loaded = 1'b0;
  int         rd_cnt = 0, wr_cnt = 0, clr_cnt = 0, both_cnt = 0;
  int         rd_row = -1, rd_col = -1, wr_row = -1, wr_col = -1, wr_dat = -1;

  // Map storage: loads the test map once, then serves 1-cycle reads and writes.
  always @(posedge clock) begin
    if (!loaded) begin
      for (int r = 0; r < int'(ROWS); r++)
        for (int c = 0; c < int'(COLS); c++) mem[r][c] <= 4'd0;
      mem[0][2] <= 4'd1;
      mem[1][1] <= 4'd5;
      mem[1][2] <= 4'd2;
      mem[2][1] <= 4'd3;
      mem[2][2] <= 4'd4;
      mem[3][2] <= 4'd9;
      mem[2][3] <= 4'd5;
      map_rd_data <= 4'd0;
      loaded <= 1'b1;
    end else begin
      if (map_rd_en && map_row < 4'(ROWS) && map_col < 5'(COLS)) begin
        map_rd_data <= mem[map_row][map_col];
      end
      if (map_wr_en && map_row < 4'(ROWS) && map_col < 5'(COLS)) begin
        mem[map_row][map_col] <= map_wr_data;
      end
      if (map_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        rd_row <= int'(map_row);
        rd_col <= int'(map_col);
      end
      if (map_wr_en) begin
        wr_cnt <= wr_cnt + 1;
        wr_row <= int'(map_row);
        wr_col <= int'(map_col);
        wr_dat <= int'(map_wr_data);
      end
      if (clearing) clr_cnt <= clr_cnt + 1;
      if (map_rd_en && map_wr_en) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [1:0] code, input int row, input int col,
                              input logic black, input int lat, input int clr,
                              input int rd, input int wr);
    exp_t e;
    e.code = code; e.row = row; e.col = col; e.black = black;
    e.lat = lat; e.clr = clr; e.rd = rd; e.wr = wr;
    return e;
  endfunction

  // Issue one command, wait (bounded) for its response and score it.
  task automatic send(input logic [1:0] dir, input exp_t e);
    int   rd0, wr0, clr0, lat;
    bit   acc, got;
    exp_t x;
    exp_q.push_back(e);
    rd0 = rd_cnt; wr0 = wr_cnt; clr0 = clr_cnt;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin acc = 1'b1; break; end
      @(negedge clock);
    end
    check("accept", 32'(acc), 32'd1);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin
        cmd_valid = 1'b0;
        check("ready_drop", 32'(cmd_ready), 32'd0);
        check("busy_hi", 32'(busy), 32'd1);
      end
      if (resp_valid === 1'b1) begin got = 1'b1; lat = k; break; end
    end
    check("resp_seen", 32'(got), 32'd1);
    x = exp_q.pop_front();
    check("latency", lat, x.lat);
    check("resp_code", 32'(resp_code), 32'(x.code));
    check("pos_row", 32'(pos_row), x.row);
    check("pos_col", 32'(pos_col), x.col);
    check("at_black", 32'(at_black), 32'(x.black));
    check("clear_cycles", clr_cnt - clr0, x.clr);
    check("rd_strobes", rd_cnt - rd0, x.rd);
    check("wr_strobes", wr_cnt - wr0, x.wr);
    @(negedge clock);
    check("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pos_row"}, 32'(pos_row), 32'd0);
    check({tag, "_pos_col"}, 32'(pos_col), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_code"}, 32'(resp_code), 32'd0);
    check({tag, "_at_black"}, 32'(at_black), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_clearing"}, 32'(clearing), 32'd0);
    check({tag, "_rd_en"}, 32'(map_rd_en), 32'd0);
    check({tag, "_wr_en"}, 32'(map_wr_en), 32'd0);
    check({tag, "_map_row"}, 32'(map_row), 32'd0);
    check({tag, "_map_col"}, 32'(map_col), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int nclr, wr0;
    bit hit;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clock);

    send(2'd0, mk(2'd2, 0, 0, 1'b0, 2, 0, 0, 0));   // N from row 0: edge
    send(2'd1, mk(2'd0, 0, 1, 1'b0, 3, 0, 1, 0));   // E onto free cell
    check("rd_addr_row", rd_row, 0);
    check("rd_addr_col", rd_col, 1);
    send(2'd1, mk(2'd1, 0, 1, 1'b0, 3, 0, 1, 0));   // E into wall
    send(2'd2, mk(2'd3, 1, 1, 1'b0, 13, 9, 1, 1));  // S onto heavy debris
    check("wr_addr_row", wr_row, 1);
    check("wr_addr_col", wr_col, 1);
    check("wr_data", wr_dat, 0);
    check("cell_cleared", 32'(mem[1][1]), 32'd0);
    send(2'd1, mk(2'd0, 1, 2, 1'b1, 3, 0, 1, 0));   // E onto black cell
    send(2'd3, mk(2'd0, 1, 1, 1'b0, 3, 0, 1, 0));   // W back onto cleared cell
    send(2'd2, mk(2'd3, 2, 1, 1'b0, 7, 3, 1, 1));   // S onto light debris
    send(2'd1, mk(2'd3, 2, 2, 1'b0, 10, 6, 1, 1));  // E onto medium debris
    send(2'd2, mk(2'd1, 2, 2, 1'b0, 3, 0, 1, 0));   // S into value-9 cell

    // Heavy clear at (2,3) aborted by reset in its fourth clearing cycle.
    wr0 = wr_cnt;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_dir   = 2'd1;
    nclr = 0;
    hit  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      if (clearing === 1'b1) nclr++;
      if (nclr == 4) begin hit = 1'b1; break; end
    end
    check("mid_clear_reached", 32'(hit), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check("abort_no_write", wr_cnt - wr0, 0);
    check("abort_cell_kept", 32'(mem[2][3]), 32'd5);
    @(negedge clock);

    send(2'd3, mk(2'd2, 0, 0, 1'b0, 2, 0, 0, 0));   // W from col 0: edge
    send(2'd1, mk(2'd0, 0, 1, 1'b0, 3, 0, 1, 0));   // normal move after abort

    check("rd_wr_overlap", both_cnt, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/robot_move_controller.md
Name: robot_move_controller

Overview:
- Sequences one robot step at a time on the 11x20 cell map (values 0 free, 1 wall, 2 black cell, 3/4/5 light/medium/heavy debris).
- Accepts a direction command and reads the target cell through a 1-cycle-latency synchronous map port.
- Decides whether to move, block, or clear debris first. Clearing takes 3, 6 or 9 cycles and writes the cell back to 0.
- Sits between the navigation logic (command/response handshake) and the map storage that feeds the graphics block.

Parameters:
- ROWS, 11, number of map rows (row index 0..ROWS-1)
- COLS, 20, number of map columns (col index 0..COLS-1)
- START_ROW, 0, robot row after reset
- START_COL, 0, robot column after reset
- LIGHT_CYC, 3, clear cycles for cell value 3
- MED_CYC, 6, clear cycles for cell value 4
- HEAVY_CYC, 9, clear cycles for cell value 5

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  direction command present
- cmd_dir  in  2  0 North (row-1), 1 East (col+1), 2 South (row+1), 3 West (col-1)
- cmd_ready  out  1  high only in IDLE
- resp_valid  out  1  one-cycle pulse at end of every accepted command
- resp_code  out  2  0 MOVED, 1 WALL, 2 EDGE, 3 CLEARED_MOVED; valid with resp_valid
- at_black  out  1  with resp_valid: robot now stands on a value-2 cell
- pos_row  out  4  current robot row
- pos_col  out  5  current robot column
- busy  out  1  state != IDLE
- clearing  out  1  high during CLEAR state
- map_rd_en  out  1  map read strobe
- map_row  out  4  map read/write row address
- map_col  out  5  map read/write column address
- map_rd_data  in  4  cell value, valid the cycle after map_rd_en
- map_wr_en  out  1  map write strobe
- map_wr_data  out  4  write value; always 0

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pos_row=START_ROW, pos_col=START_COL.
  - resp_valid=0, resp_code=0, at_black=0, busy=0, clearing=0.
  - map_rd_en=0, map_wr_en=0, map address=0, clear counter=0.
  - Reset mid-operation aborts the command with no response and no map write.
- FSM states: IDLE, CHECK, EVAL, CLEAR, WRITE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1, latch cmd_dir and go to CHECK; cmd_ready drops the next cycle.
- CHECK:
  - Compute the target cell from pos_row/pos_col and the latched direction.
  - Out of bounds (row 0 going N, row ROWS-1 going S, col 0 going W, col COLS-1 going E): resp_code=EDGE, go to RESP, no map access.
  - Otherwise drive map_rd_en=1 with the target address this same cycle and go to EVAL.
- EVAL: sample map_rd_data.
  - 0 or 2: update position to the target; resp_code=MOVED; at_black=(value==2); go to RESP.
  - 1 or 6..15: resp_code=WALL; position unchanged; go to RESP.
  - 3/4/5: load the counter with LIGHT_CYC/MED_CYC/HEAVY_CYC; go to CLEAR.
- CLEAR:
  - clearing=1; counter decrements each cycle.
  - Leave to WRITE in the cycle the counter equals 1, so CLEAR lasts exactly N cycles.
  - Map address is held on the target cell.
- WRITE:
  - map_wr_en=1 and map_wr_data=0 for exactly one cycle at the target address.
  - Update position to the target; resp_code=CLEARED_MOVED; at_black=0; go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. resp_code and at_black hold until the next response.
- Latency, with the command accepted at edge T:
  - Free move or wall: resp_valid at T+3.
  - Edge: resp_valid at T+2.
  - Debris: resp_valid at T+4+N.
  - New pos_row/pos_col are visible in the RESP cycle.
- Commands are not queued. cmd_valid outside IDLE is ignored; the requester holds it until cmd_ready.
- Back-to-back: a command presented during RESP is accepted on the first IDLE cycle.
- map_rd_en and map_wr_en are never high in the same cycle.

Test Plan:
- Reset with START=(0,0); cmd_dir=1 (E), map(0,1)=0 -> map_rd_en at T+1 with address (0,1); resp_valid at T+3 with code 0; pos=(0,1).
- At (0,0), cmd_dir=0 (N) -> resp_valid at T+2 with code 2 (EDGE); no map_rd_en; pos unchanged.
- map(0,2)=1, cmd E from (0,1) -> code 1 (WALL); pos stays (0,1); no map_wr_en.
- map(1,1)=5, cmd S from (0,1) -> clearing high exactly 9 cycles; one map_wr_en writing 0 to (1,1); resp_valid at T+13 with code 3; pos=(1,1). Repeat with values 3 and 4 -> 3 and 6 clearing cycles.
- map(1,2)=2, cmd E -> code 0, at_black=1, pos=(1,2). Then cmd W onto a 0 cell -> at_black=0.
- Assert reset_n low in CLEAR cycle 4 of a heavy clear -> outputs at reset values immediately; no map_wr_en; pos=START; next command handled normally.
